mfda_source_dispenser: RTL
==========================

// Module: mfda_source_dispenser
// PURPOSE
// - Digital controller for the fluid inlet feeding the Source port of the synthetic chamber/mixer networks.
// - Meters fluid as a programmed train of valve pulses, then holds a settle window.
// - Signals completion so the host can sample the network output.
// - Sits directly upstream of the Source inlet; one instance drives one inlet valve/pump pair.
// PARAMETERS
// - CNT_W    16  width of the on/off/settle cycle counts
// - PULSE_W  8   width of the pulse-count request and the pulses_sent counter
// PORTS
// - clk          in   1        single clock; all logic on posedge
// - rst          in   1        synchronous, active-high reset
// - start        in   1        begin a dispense; sampled only in IDLE
// - abort        in   1        cancel an active dispense
// - pulse_count  in   PULSE_W  number of valve pulses; latched on accepted start
// - on_cycles    in   CNT_W    valve-open cycles per pulse; latched; 0 is treated as 1
// - off_cycles   in   CNT_W    valve-closed gap between pulses; latched; 0 allowed
// - settle_cycles in  CNT_W    closed hold after the last pulse; latched; 0 allowed
// - valve_open   out  1        inlet valve drive, registered
// - pump_en      out  1        pump drive, registered
// - busy         out  1        dispense in progress
// - done         out  1        one-cycle pulse on normal completion
// - aborted      out  1        one-cycle pulse when abort is taken
// - cfg_err      out  1        one-cycle pulse when start is accepted with pulse_count==0
// - pulses_sent  out  PULSE_W  pulses completed in the current or last run
// BEHAVIOUR
// - Reset: all outputs 0, pulses_sent 0, state IDLE. Reset mid-run closes the valve at that edge and emits no done.
// - FSM states: IDLE, ON, OFF, SETTLE, FIN.
// - IDLE, start=1 at edge T:
//   - Latch config; clear pulses_sent.
//   - If pulse_count==0: cfg_err=1 during T+1 and stay IDLE.
//   - Otherwise go to ON; from T+1, valve_open=1, pump_en=1, busy=1.
// - ON: valve_open=1 for exactly on_cycles cycles. On the last ON cycle, pulses_sent increments (visible next cycle).
//   - More pulses remain and off_cycles>0: go to OFF.
//   - More pulses remain and off_cycles==0: re-enter ON, so the valve stays high continuously.
//   - Last pulse: go to SETTLE, or to FIN if settle_cycles==0.
// - OFF: valve_open=0 and pump_en=1 for exactly off_cycles cycles, then ON.
// - SETTLE: valve_open=0 and pump_en=0 for exactly settle_cycles cycles, then FIN.
// - FIN: one cycle with done=1 and busy=1; busy=0 from the next cycle; return to IDLE.
// - start while busy is ignored; config inputs are ignored after latching.
// - abort (any state except IDLE) at edge A: next cycle valve_open=0, pump_en=0, busy=0, aborted=1, state IDLE, pulses_sent holds.
// - abort and start together in IDLE: start wins; abort is ignored.
// - abort coinciding with the final FIN cycle: done wins (already complete).
// - Total busy cycles for N pulses: N*on + (N-1)*off + settle + 1.
// - Counters are down-counters loaded with (value-1); no wrap. pulses_sent saturates at pulse_count by construction.
// STRUCTURE
// - Shared package mfda_ctrl_pkg:
//   - disp_state_t enum (IDLE, ON, OFF, SETTLE, FIN)
//   - default CNT_W and PULSE_W localparams
// - One sub-module: mfda_down_counter (load, dec, zero flag), instanced once for phase timing.
// - Pulse counting stays inline.
// TESTING
// - Basic run: pulse_count=3, on=4, off=2, settle=5 -> valve pattern 1111_00_1111_00_1111, then 5 zeros.
//   done at busy cycle 22; pulses_sent=3.
// - Merged pulses: off=0, pulse_count=2, on=3 -> valve high for 6 consecutive cycles.
//   settle=0 -> done in the cycle immediately after the valve falls.
// - Bad config: start with pulse_count=0 -> cfg_err one cycle, busy/valve never rise, pulses_sent=0.
// - on_cycles=0 with pulse_count=1, settle=0 -> valve high 1 cycle, done the following cycle.
// - Abort in the 2nd OFF gap of a 3-pulse run -> valve/pump/busy low next cycle, aborted=1, no done, pulses_sent=2.
//   start while busy is ignored.
// - Reset asserted during ON -> all outputs 0 next cycle.
//   A following start with the same config reproduces the basic-run waveform exactly.

Source files
------------

// File: rtl/mfda_ctrl_pkg.sv
// Shared types and default widths for the MFDA source-inlet dispenser.
package mfda_ctrl_pkg;

   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned PULSE_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ON     = 3'd1,
      OFF    = 3'd2,
      SETTLE = 3'd3,
      FIN    = 3'd4
   } disp_state_t;

endpackage

// File: rtl/mfda_down_counter.sv
// Loadable, non-wrapping down-counter with a registered zero flag.
module mfda_down_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         zero_o  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_o  <= (count_d == '0);
      end
   end

endmodule

// File: rtl/mfda_source_dispenser.sv
// Source-inlet controller: meters a train of valve pulses, holds a settle window,
// then flags completion so the host can sample the network output.
module mfda_source_dispenser
   import mfda_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned PULSE_W = PULSE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [PULSE_W-1:0] pulse_count,
   input  logic [CNT_W-1:0]   on_cycles,
   input  logic [CNT_W-1:0]   off_cycles,
   input  logic [CNT_W-1:0]   settle_cycles,
   output logic               valve_open,
   output logic               pump_en,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic               cfg_err,
   output logic [PULSE_W-1:0] pulses_sent
);

   disp_state_t        state_q, state_d;
   logic [PULSE_W-1:0] pc_q, pc_d;
   logic [PULSE_W-1:0] ps_q, ps_d;
   logic [PULSE_W-1:0] ps_inc;
   logic [CNT_W-1:0]   on_q, on_d;
   logic [CNT_W-1:0]   off_q, off_d;
   logic [CNT_W-1:0]   settle_q, settle_d;
   logic               cnt_load;
   logic [CNT_W-1:0]   cnt_val;
   logic               cnt_zero;
   logic               aborted_d;
   logic               cfg_err_d;

   // Phase length n is timed by loading n-1; a zero length collapses to one cycle.
   function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   assign ps_inc = ps_q + PULSE_W'(1);

   mfda_down_counter #(.W(CNT_W)) u_phase_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (!cnt_load),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ps_d      = ps_q;
      on_d      = on_q;
      off_d     = off_q;
      settle_d  = settle_q;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      aborted_d = 1'b0;
      cfg_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               pc_d     = pulse_count;
               on_d     = on_cycles;
               off_d    = off_cycles;
               settle_d = settle_cycles;
               ps_d     = '0;
               if (pulse_count == '0) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d  = ON;
                  cnt_load = 1'b1;
                  cnt_val  = phase_load(on_cycles);
               end
            end
         end
         ON: begin
            if (cnt_zero) begin
               ps_d = ps_inc;
               if (ps_inc != pc_q) begin
                  cnt_load = 1'b1;
                  if (off_q != '0) begin
                     state_d = OFF;
                     cnt_val = phase_load(off_q);
                  end else begin
                     state_d = ON;
                     cnt_val = phase_load(on_q);
                  end
               end else if (settle_q != '0) begin
                  state_d  = SETTLE;
                  cnt_load = 1'b1;
                  cnt_val  = phase_load(settle_q);
               end else begin
                  state_d = FIN;
               end
            end
         end
         OFF: begin
            if (cnt_zero) begin
               state_d  = ON;
               cnt_load = 1'b1;
               cnt_val  = phase_load(on_q);
            end
         end
         SETTLE: begin
            if (cnt_zero) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // FIN is already complete, so abort only cancels the metering phases.
      if (abort && (state_q inside {ON, OFF, SETTLE})) begin
         state_d   = IDLE;
         ps_d      = ps_q;
         cnt_load  = 1'b0;
         cnt_val   = '0;
         aborted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         ps_q        <= '0;
         on_q        <= '0;
         off_q       <= '0;
         settle_q    <= '0;
         valve_open  <= 1'b0;
         pump_en     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ps_q        <= ps_d;
         on_q        <= on_d;
         off_q       <= off_d;
         settle_q    <= settle_d;
         valve_open  <= (state_d == ON);
         pump_en     <= (state_d == ON) || (state_d == OFF);
         busy        <= (state_d != IDLE);
         done        <= (state_d == FIN);
         aborted     <= aborted_d;
         cfg_err     <= cfg_err_d;
      end
   end

   assign pulses_sent = ps_q;

endmodule
